// File: rtl/i2s_sample_packer_if.sv
// i2s_sample_packer_if
// Byte stream from the I2S sample packer to the UDP payload builder.
// Ports / signals:
//   m_data  - output byte (8 bits)
//   m_valid - byte valid, held high for the whole packet
//   m_ready - downstream ready
//   m_last  - marks the final byte of a packet
// Modports: master (packer side), slave (consumer side).
interface i2s_sample_packer_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/i2s_sample_packer.sv
// i2s_sample_packer
// Captures completed stereo frames from the 24-bit I2S receive driver into a
// frame FIFO and streams them out as packet-aligned big-endian byte packets.
// Frames arriving while the FIFO is full (and not being popped) are dropped
// and counted.
// Ports:
//   mclk, rst    - clock and synchronous active-high reset
//   rch1, rch2   - left / right 24-bit samples
//   in_valid     - driver valid flag (mclk domain)
//   in_lrclk     - raw LRCLK pin, asynchronous to mclk
//   stream       - byte stream master (m_data/m_valid/m_ready/m_last)
//   fifo_count   - frames currently buffered
//   overflow     - sticky, set on the first dropped frame
//   drop_count   - saturating count of dropped frames
// Configuration macro: I2S_PACKER_SEQ_HDR_EN prefixes each packet with a
// 2-byte big-endian sequence number.
module i2s_sample_packer #(
  parameter int DEPTH          = 16,
  parameter int FRAMES_PER_PKT = 8
) (
  input  logic                     mclk,
  input  logic                     rst,
  input  logic [23:0]              rch1,
  input  logic [23:0]              rch2,
  input  logic                     in_valid,
  input  logic                     in_lrclk,
  i2s_sample_packer_if.master      stream,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [15:0]              drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = (FRAMES_PER_PKT > 1) ? $clog2(FRAMES_PER_PKT) : 1;
  localparam logic [CW-1:0] FPP_C      = CW'(FRAMES_PER_PKT);
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [FW-1:0] LAST_FRAME = FW'(FRAMES_PER_PKT - 1);

`ifdef I2S_PACKER_SEQ_HDR_EN
  typedef enum logic [1:0] {IDLE, HDR_HI, HDR_LO, DATA} state_t;
  localparam state_t FIRST = HDR_HI;
  logic [15:0] seq;
`else
  typedef enum logic [1:0] {IDLE, DATA} state_t;
  localparam state_t FIRST = DATA;
`endif

  logic          lr_meta, lr_s, v_q;
  logic          capture, full, push, pop, drop, hs;
  logic [47:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
  logic [47:0]   head_n;

  state_t        state, state_n;
  logic [2:0]    b, b_n;
  logic [FW-1:0] frame, frame_n;
  logic [7:0]    data_n;
  logic          valid_n, last_n;

  // LRCLK synchroniser and valid edge detector
  always_ff @(posedge mclk) begin
    if (rst) begin
      lr_meta <= 1'b0;
      lr_s    <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      lr_meta <= in_lrclk;
      lr_s    <= lr_meta;
      v_q     <= in_valid;
    end
  end

  // A frame is complete on the valid rising edge while the right channel is active.
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign capture = in_valid & ~v_q & lr_s;
  assign full    = (fifo_count == DEPTH_C);
  assign push    = capture & (~full | pop);
  assign drop    = capture & full & ~pop;
  assign hs      = stream.m_valid & stream.m_ready;

  always_ff @(posedge mclk) begin
    if (push) mem[wr_ptr] <= {rch1, rch2};
  end

  // FIFO pointers, occupancy and drop accounting
  always_ff @(posedge mclk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      drop_count <= 16'h0000;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_n;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
    end
  end

  // Next-state logic; outputs for the next byte are derived from the next state
  // so the registered outputs always describe the byte currently presented.
  always_comb begin
    state_n = state;
    b_n     = b;
    frame_n = frame;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_count >= FPP_C) begin
          state_n = FIRST;
          b_n     = 3'd0;
          frame_n = '0;
        end
      end
`ifdef I2S_PACKER_SEQ_HDR_EN
      HDR_HI: if (hs) state_n = HDR_LO;
      HDR_LO: if (hs) state_n = DATA;
`endif
      DATA: begin
        if (hs) begin
          if (b == 3'd5) begin
            pop = 1'b1;
            b_n = 3'd0;
            if (frame == LAST_FRAME) begin
              state_n = IDLE;
              frame_n = '0;
            end else begin
              frame_n = frame + FW'(1);
            end
          end else begin
            b_n = b + 3'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    rd_ptr_n = pop ? rd_ptr + AW'(1) : rd_ptr;
    head_n   = mem[rd_ptr_n];

    valid_n = (state_n != IDLE);
    data_n  = 8'h00;
    last_n  = 1'b0;
    case (state_n)
`ifdef I2S_PACKER_SEQ_HDR_EN
      HDR_HI: data_n = seq[15:8];
      HDR_LO: data_n = seq[7:0];
`endif
      DATA: begin
        case (b_n)
          3'd0:    data_n = head_n[47:40];
          3'd1:    data_n = head_n[39:32];
          3'd2:    data_n = head_n[31:24];
          3'd3:    data_n = head_n[23:16];
          3'd4:    data_n = head_n[15:8];
          default: data_n = head_n[7:0];
        endcase
        last_n = (b_n == 3'd5) && (frame_n == LAST_FRAME);
      end
      default: data_n = 8'h00;
    endcase
  end

  // State and output registers only advance when the current byte is consumed
  // (or nothing is presented), which keeps m_data/m_last stable under backpressure.
  always_ff @(posedge mclk) begin
    if (rst) begin
      state          <= IDLE;
      b              <= 3'd0;
      frame          <= '0;
      stream.m_data  <= 8'h00;
      stream.m_valid <= 1'b0;
      stream.m_last  <= 1'b0;
    end else if (~stream.m_valid | stream.m_ready) begin
      state          <= state_n;
      b              <= b_n;
      frame          <= frame_n;
      stream.m_data  <= data_n;
      stream.m_valid <= valid_n;
      stream.m_last  <= last_n;
    end
  end

`ifdef I2S_PACKER_SEQ_HDR_EN
  // Sequence number advances once per completed packet
  always_ff @(posedge mclk) begin
    if (rst) seq <= 16'h0000;
    else if (hs & stream.m_last) seq <= seq + 16'd1;
  end
`endif

endmodule
